// File: rtl/layer_1_pkg.sv
// Shared definitions for the layer-1 neuron stage: sequencer state encoding
// and the default pipeline geometry shared with the product pipeline.
package layer_1_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_NUM_INPUTS  = 256;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_MAC_LATENCY = 2;

endpackage

// File: rtl/layer_1_valid_pipe.sv
// Issue-valid delay line: carries one bit per cycle from pixel issue to the
// point where the matching product reaches the accumulator inputs.
module layer_1_valid_pipe
  import layer_1_pkg::*;
#(
  parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic tap
);

  logic [MAC_LATENCY-1:0] vld_p;

  generate
    if (MAC_LATENCY == 1) begin : g_one
      // Single-stage delay; cleared on reset so no stale strobe survives.
      always_ff @(posedge clk) begin
        if (!reset) vld_p <= '0;
        else        vld_p <= issue;
      end
    end else begin : g_shift
      // Shift issue bits toward the tap; cleared on reset to flush in-flight strobes.
      always_ff @(posedge clk) begin
        if (!reset) vld_p <= '0;
        else        vld_p <= {vld_p[MAC_LATENCY-2:0], issue};
      end
    end
  endgenerate

  assign tap = vld_p[MAC_LATENCY-1];

endmodule

// File: rtl/layer_1_sequencer.sv
// Layer-1 neuron stage sequencer: clears the bias accumulator, walks the
// pixel index through image buffer and weight ROM, and aligns the
// accumulator load strobe with the product pipeline.
// Optional feature macro: ZERO_SKIP_EN (gate acc_load with pixel_bit).
module layer_1_sequencer
  import layer_1_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  pixel_bit,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic                  acc_clear,
  output logic                  acc_load,
  output logic                  busy,
  output logic                  done
);

  localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(MAC_LATENCY - 1);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               issue;
  logic               tap;

  // An issue is an ISSUE-state cycle where the image buffer has the pixel ready.
  assign issue = (state == ISSUE) && in_valid;

  // Control FSM with address counter; all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pixel_addr <= '0;
      drain_cnt  <= '0;
      acc_clear  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            pixel_addr <= '0;
            acc_clear  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        CLEAR: begin
          state <= ISSUE;
        end
        ISSUE: begin
          if (in_valid) begin
            if (pixel_addr == LAST_ADDR) begin
              // Final index stays on the bus; no wrap back to zero.
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              pixel_addr <= pixel_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          pixel_addr <= '0;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          pixel_addr <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  layer_1_valid_pipe #(
    .MAC_LATENCY(MAC_LATENCY)
  ) u_valid_pipe (
    .clk  (clk),
    .reset(reset),
    .issue(issue),
    .tap  (tap)
  );

`ifdef ZERO_SKIP_EN
  // Zero pixels contribute nothing, so skip the accumulator update entirely.
  assign acc_load = tap & pixel_bit;
`else
  // Weight path multiplies by the pixel; every issued product is loaded.
  logic unused_pixel_bit;
  assign unused_pixel_bit = pixel_bit;
  assign acc_load = tap;
`endif

endmodule

// File: tb/tb_layer_1_sequencer.sv
// Testbench for layer_1_sequencer: event-level reference model plus
// directed scenarios and randomized traffic.
module tb_layer_1_sequencer;

  localparam int N  = 256;
  localparam int AW = 8;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          pixel_bit = 1'b1;
  logic [AW-1:0] pixel_addr;
  logic          acc_clear;
  logic          acc_load;
  logic          busy;
  logic          done;

  layer_1_sequencer #(
    .NUM_INPUTS (N),
    .ADDR_WIDTH (AW),
    .MAC_LATENCY(L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .pixel_bit (pixel_bit),
    .pixel_addr(pixel_addr),
    .acc_clear (acc_clear),
    .acc_load  (acc_load),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is described by when it was accepted, which cycles issued a pixel,
  // and when the last issue happened; outputs follow from those events.
  bit armed = 1'b0;
  bit run = 1'b0;
  int t_start = -10;
  int issued = 0;
  int done_cyc = -1;
  bit issue_at[int];
  int issue_idx[int];

  // run statistics, relative to a base cycle chosen by the directed tests
  int base = 0;
  int n_clear, clr1, clr2, n_load, ld_first, ld_last, n_done, done_rel, fall_rel;
  bit seen_busy;

  task automatic arm(input int b);
    base = b; n_clear = 0; clr1 = -1; clr2 = -1; n_load = 0; ld_first = -1;
    ld_last = -1; n_done = 0; done_rel = -1; fall_rel = -1; seen_busy = 1'b0;
  endtask

  always @(negedge clk) begin : model_cmp
    bit e_busy, e_clear, e_done, e_load;
    int e_addr;
    e_busy  = run && (cyc >= t_start) && (done_cyc < 0 || cyc <= done_cyc);
    e_clear = run && (cyc == t_start);
    e_done  = run && (cyc == done_cyc);
    e_addr  = e_busy ? ((issued < N - 1) ? issued : N - 1) : 0;
    e_load  = issue_at.exists(cyc - L);
`ifdef ZERO_SKIP_EN
    e_load  = e_load & pixel_bit;
`endif
    if (armed) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("acc_clear", 32'(acc_clear), 32'(e_clear));
      check("done", 32'(done), 32'(e_done));
      check("acc_load", 32'(acc_load), 32'(e_load));
      check("pixel_addr", 32'(pixel_addr), e_addr);
      if (acc_clear === 1'b1) begin
        n_clear++;
        if (n_clear == 1) clr1 = cyc - base;
        else if (n_clear == 2) clr2 = cyc - base;
      end
      if (acc_load === 1'b1) begin
        n_load++;
        if (ld_first < 0) ld_first = cyc - base;
        ld_last = cyc - base;
      end
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) done_rel = cyc - base;
      end
      if (busy === 1'b1) seen_busy = 1'b1;
      else if (seen_busy && fall_rel < 0) fall_rel = cyc - base;
    end
    // advance the model with this cycle's inputs
    if (!reset) begin
      armed = 1'b1; run = 1'b0; issued = 0; done_cyc = -1;
      issue_at.delete(); issue_idx.delete();
    end else begin
      if (run && cyc > t_start && issued < N && in_valid) begin
        issue_at[cyc] = 1'b1;
        issue_idx[cyc] = issued;
        issued++;
        if (issued == N) done_cyc = cyc + L + 1;
      end
      if (run && cyc == done_cyc) run = 1'b0;
      if (!e_busy && start) begin
        run = 1'b1; t_start = cyc + 1; issued = 0; done_cyc = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input int stall_at, input bit pmode);
    int stalls;
    int k;
    int v;
    stalls = 0;
    k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
      if (stall_at >= 0 && busy === 1'b1 && int'(pixel_addr) == stall_at && stalls < 3) begin
        in_valid = 1'b0;
        stalls++;
      end else begin
        in_valid = 1'b1;
      end
      if (pmode) begin
        if (issue_idx.exists(cyc - L)) begin
          v = issue_idx[cyc - L];
          pixel_bit = ~v[0];
        end else begin
          pixel_bit = 1'b0;
        end
      end
    end
    if (n_done < target) check("done_timeout", n_done, target);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    start = 1'b0;
    in_valid = 1'b1;
    reset = 1'b1;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    // reset hold, with start asserted on the same edge as reset
    repeat (3) tick();
    start = 1'b1;
    arm(cyc);
    tick();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_start_no_clear", n_clear, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(pixel_addr), 0);

    // nominal run, no stalls
    tick();
    start = 1'b1; in_valid = 1'b1; pixel_bit = 1'b1;
    arm(cyc);
    tick();
    start = 1'b0;
    wait_done(1, 400, -1, 1'b0);
    repeat (3) tick();
    check("nom_clear_cyc", clr1, 1);
    check("nom_clear_cnt", n_clear, 1);
    check("nom_load_first", ld_first, 4);
    check("nom_load_last", ld_last, 259);
    check("nom_load_cnt", n_load, 256);
    check("nom_done_cyc", done_rel, 260);
    check("nom_done_cnt", n_done, 1);
    check("nom_busy_fall", fall_rel, 261);

    // three stall cycles at pixel_addr 10
    tick();
    start = 1'b1; in_valid = 1'b1;
    arm(cyc);
    tick();
    start = 1'b0;
    wait_done(1, 400, 10, 1'b0);
    repeat (3) tick();
    check("stall_done_cyc", done_rel, 263);
    check("stall_load_cnt", n_load, 256);
    check("stall_load_last", ld_last, 262);

    // reset mid-run at cycle 100, restart at cycle 110
    tick();
    start = 1'b1; in_valid = 1'b1;
    arm(cyc);
    tick();
    start = 1'b0;
    repeat (98) tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (8) tick();
    tick();
    start = 1'b1;
    check("abort_no_done", n_done, 0);
    check("abort_busy", 32'(busy), 0);
    arm(cyc);
    tick();
    start = 1'b0;
    wait_done(1, 400, -1, 1'b0);
    repeat (3) tick();
    check("restart_clear_cyc", clr1, 1);
    check("restart_load_first", ld_first, 4);
    check("restart_done_cyc", done_rel, 260);
    check("restart_load_cnt", n_load, 256);

    // start held high throughout
    tick();
    start = 1'b1; in_valid = 1'b1;
    arm(cyc);
    k = 0;
    while (n_clear < 2 && k < 600) begin
      tick();
      k++;
    end
    check("held_second_clear", clr2, 262);
    check("held_done_cyc", done_rel, 260);
    check("held_busy_fall", fall_rel, 261);
    start = 1'b0;
    wait_done(2, 400, -1, 1'b0);
    repeat (3) tick();
    check("held_done_cnt", n_done, 2);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      start     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      pixel_bit = 1'($urandom_range(0, 1));
      reset     = !($urandom_range(0, 599) == 0);
    end
    wait_idle(700);

    // pixel_bit set only for even indices
    tick();
    start = 1'b1; in_valid = 1'b1; pixel_bit = 1'b0;
    arm(cyc);
    tick();
    start = 1'b0;
    wait_done(1, 400, -1, 1'b1);
    repeat (3) tick();
    check("parity_done_cyc", done_rel, 260);
`ifdef ZERO_SKIP_EN
    check("parity_load_cnt", n_load, 128);
`else
    check("parity_load_cnt", n_load, 256);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
